// File: rtl/if_inst_queue.sv
// Instruction queue between the ICache response (fetch) and decode.
// Holds up to DEPTH {PC, instruction, exception tag} entries and presents
// the oldest one to decode. Two flush flavours: flush_all drops everything,
// and flush_keep_head keeps only the head entry, which is the delay slot of
// a branch that was just resolved.
module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic [EXC_W-1:0]           in_exc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [EXC_W-1:0]           out_exc,
  input  logic                       out_ready,
  input  logic                       flush_all,
  input  logic                       flush_keep_head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LP_PTR_ONE = PW'(1);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);

  // Entry storage; contents are never reset, validity comes from r_count.
  logic [31:0]      r_mem_pc    [DEPTH];
  logic [31:0]      r_mem_instr [DEPTH];
  logic [EXC_W-1:0] r_mem_exc   [DEPTH];

  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_wen;
  logic [PW-1:0] w_waddr;
  logic [PW-1:0] w_nxt_rptr;
  logic [PW-1:0] w_nxt_wptr;
  logic [CW-1:0] w_nxt_count;

  // Handshake: no pass-through when full, so a same-cycle pop never raises in_ready.
  assign w_in_ready  = (r_count < LP_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_pc    = r_mem_pc[r_rptr];
  assign out_instr = r_mem_instr[r_rptr];
  assign out_exc   = r_mem_exc[r_rptr];
  assign count     = r_count;

  // Next pointers/occupancy and array write decision, flush_all taking priority.
  always_comb begin
    w_nxt_rptr  = r_rptr;
    w_nxt_wptr  = r_wptr;
    w_nxt_count = r_count;
    w_wen       = 1'b0;
    w_waddr     = r_wptr;
    if (flush_all) begin
      w_nxt_rptr  = '0;
      w_nxt_wptr  = '0;
      w_nxt_count = '0;
    end else if (flush_keep_head) begin
      if (r_count == '0) begin
        // Late delay-slot fetch: restart at slot 0 and keep the incoming entry.
        w_nxt_rptr = '0;
        w_waddr    = '0;
        if (w_push) begin
          w_wen       = 1'b1;
          w_nxt_wptr  = LP_PTR_ONE;
          w_nxt_count = LP_CNT_ONE;
        end else begin
          w_nxt_wptr  = '0;
          w_nxt_count = '0;
        end
      end else if (w_pop) begin
        // Delay slot leaves this cycle; nothing survives.
        w_nxt_rptr  = r_rptr + LP_PTR_ONE;
        w_nxt_wptr  = r_rptr + LP_PTR_ONE;
        w_nxt_count = '0;
      end else begin
        // Keep only the head; anything behind it and any new push is dropped.
        w_nxt_wptr  = r_rptr + LP_PTR_ONE;
        w_nxt_count = LP_CNT_ONE;
      end
    end else begin
      if (w_push) begin
        w_wen      = 1'b1;
        w_nxt_wptr = r_wptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        w_nxt_rptr = r_rptr + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   w_nxt_count = r_count + LP_CNT_ONE;
        2'b01:   w_nxt_count = r_count - LP_CNT_ONE;
        default: w_nxt_count = r_count;
      endcase
    end
  end

  // Control state: pointers and occupancy, dropped immediately on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= w_nxt_rptr;
      r_wptr  <= w_nxt_wptr;
      r_count <= w_nxt_count;
    end
  end

  // Entry write into the array; data path carries no reset.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      r_mem_pc[w_waddr]    <= in_pc;
      r_mem_instr[w_waddr] <= in_instr;
      r_mem_exc[w_waddr]   <= in_exc;
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// Scoreboard bench for if_inst_queue: stimulus pushes the PCs it expects to
// reach decode into a queue; a negedge monitor pops and compares on each pop.
module tb_if_inst_queue;

  localparam int DEPTH = 4;
  localparam int EXC_W = 8;

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic [EXC_W-1:0] in_exc;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [EXC_W-1:0] out_exc;
  logic             out_ready;
  logic             flush_all;
  logic             flush_keep_head;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];

  if_inst_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
    .out_ready(out_ready),
    .flush_all(flush_all), .flush_keep_head(flush_keep_head),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic [EXC_W-1:0] exc_of(input logic [31:0] pc);
    return pc[9:2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr_of(pc);
    in_exc   = exc_of(pc);
  endtask

  // Advance past the next rising edge; inputs change and checks run here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every real pop is compared against the oldest expected PC.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush_all) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc 0x%08h expected no entry", out_pc);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        check("pop_pc", out_pc, e);
        check("pop_instr", out_instr, instr_of(e));
        check("pop_exc", {24'd0, out_exc}, {24'd0, exc_of(e)});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    offer(1'b0, 32'd0);
    out_ready = 1'b0;
    flush_all = 1'b0;
    flush_keep_head = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #3 resetn = 1'b1;
    cyc();

    // Fill to DEPTH, then a refused 5th push.
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'hBFC0_0000 + 32'(4 * i));
      expq.push_back(32'hBFC0_0000 + 32'(4 * i));
      cyc();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_pc, 32'hBFC0_0000);
    offer(1'b1, 32'hBFC0_0010);
    cyc();
    check("refused_count", 32'(count), 32'd4);
    offer(1'b0, 32'd0);

    // Drain four entries in order.
    out_ready = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_sb_empty", 32'(expq.size()), 32'd0);

    // Empty plus out_ready: nothing happens.
    out_ready = 1'b1;
    cyc();
    check("empty_pop_count", 32'(count), 32'd0);

    // Streaming push+pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'h0000_1000 + 32'(4 * i));
      expq.push_back(32'h0000_1000 + 32'(4 * i));
      cyc();
      check("stream_count", 32'(count), 32'd1);
      check("stream_head", out_pc, 32'h0000_1000 + 32'(4 * i));
    end
    offer(1'b0, 32'd0);
    cyc();
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);
    check("stream_sb_empty", 32'(expq.size()), 32'd0);

    // flush_keep_head with 3 entries, no pop, push dropped.
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h0000_0100 + 32'(4 * i));
      expq.push_back(32'h0000_0100 + 32'(4 * i));
      cyc();
    end
    offer(1'b1, 32'h0000_010C);
    flush_keep_head = 1'b1;
    while (expq.size() > 1) void'(expq.pop_back());
    cyc();
    flush_keep_head = 1'b0;
    offer(1'b0, 32'd0);
    check("fkh_count", 32'(count), 32'd1);
    check("fkh_head", out_pc, 32'h0000_0100);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("fkh_drain_count", 32'(count), 32'd0);

    // flush_keep_head on empty queue accepts the late delay-slot fetch.
    offer(1'b1, 32'h0000_0200);
    flush_keep_head = 1'b1;
    expq.push_back(32'h0000_0200);
    cyc();
    flush_keep_head = 1'b0;
    offer(1'b0, 32'd0);
    check("fkh_empty_count", 32'(count), 32'd1);
    check("fkh_empty_head", out_pc, 32'h0000_0200);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Same with flush_all also asserted: nothing stored.
    offer(1'b1, 32'h0000_0204);
    flush_all = 1'b1;
    flush_keep_head = 1'b1;
    cyc();
    flush_all = 1'b0;
    flush_keep_head = 1'b0;
    offer(1'b0, 32'd0);
    check("both_flush_count", 32'(count), 32'd0);
    check("both_flush_valid", 32'(out_valid), 32'd0);

    // flush_keep_head with head popping the same cycle: queue ends empty.
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 32'h0000_0500 + 32'(4 * i));
      expq.push_back(32'h0000_0500 + 32'(4 * i));
      cyc();
    end
    offer(1'b1, 32'h0000_0508);
    out_ready = 1'b1;
    flush_keep_head = 1'b1;
    void'(expq.pop_back());
    cyc();
    flush_keep_head = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 32'd0);
    check("fkh_pop_count", 32'(count), 32'd0);
    check("fkh_pop_sb_empty", 32'(expq.size()), 32'd0);

    // flush_all on 2 entries with pop and push offered: all ignored.
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 32'h0000_0600 + 32'(4 * i));
      cyc();
    end
    offer(1'b1, 32'h0000_0608);
    out_ready = 1'b1;
    flush_all = 1'b1;
    cyc();
    flush_all = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 32'd0);
    check("fall_count", 32'(count), 32'd0);

    // Asynchronous reset between edges with 2 entries held.
    for (int i = 0; i < 2; i++) begin
      offer(1'b1, 32'h0000_0300 + 32'(4 * i));
      cyc();
    end
    offer(1'b0, 32'd0);
    #1 resetn = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    #1 resetn = 1'b1;
    offer(1'b1, 32'h0000_0400);
    expq.push_back(32'h0000_0400);
    cyc();
    offer(1'b0, 32'd0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_head", out_pc, 32'h0000_0400);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("final_count", 32'(count), 32'd0);
    check("final_sb_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
